// File: rtl/fft_pkg.sv
// Shared FFT constants, bin/magnitude types and the frame-buffer write-FSM encoding.
// Also imported by main_fsm so both sides agree on frame geometry.
package fft_pkg;

   localparam int FRAME_LEN    = 512;
   localparam int ADDR_W       = 9;
   localparam int DATA_W       = 18;
   localparam int MIN_BIN      = 1;
   localparam int MAG_W        = 2 * DATA_W;
   localparam int FLUSH_CYCLES = 2;

   typedef logic [ADDR_W-1:0] bin_t;
   typedef logic [MAG_W-1:0]  mag_t;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_FILL,
      WR_FLUSH,
      WR_WAIT_SWAP
   } wr_state_e;

   localparam bin_t LAST_BIN    = bin_t'(FRAME_LEN - 1);
   localparam bin_t MIN_BIN_IDX = bin_t'(MIN_BIN);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/fft_bank_ram.sv
// Simple dual-port RAM: one write port, one registered read port with read enable.
// The top uses the address MSB as the ping-pong bank select.
module fft_bank_ram #(
   parameter int AW = 10,
   parameter int DW = 36
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [0:(1 << AW) - 1];
   logic [DW-1:0] rdata_q;

   // NOTE: the array has no reset so it maps onto block RAM; only the read register is cleared.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer between the FFT unload port and main_fsm, with running peak-bin search.
// Define FFT_FRAME_PEAK_EN to build the |X|^2 pipeline; otherwise peak_bin/peak_mag are tied to 0.
module fft_frame_buffer
   import fft_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] xk_index,
   input  logic [DATA_W-1:0] xk_re,
   input  logic [DATA_W-1:0] xk_im,
   input  logic              dv,
   input  logic              frame_ack,
   input  logic [ADDR_W-1:0] fft_address,
   input  logic              rd_en,
   output logic              fft_done,
   output logic              fft_read_valid,
   output logic [DATA_W-1:0] data_in_real,
   output logic [DATA_W-1:0] data_in_imag,
   output logic [ADDR_W-1:0] peak_bin,
   output logic [MAG_W-1:0]  peak_mag,
   output logic [7:0]        frames_dropped
);

   wr_state_e   state_q, state_d;
   logic        wr_bank_q, wr_bank_d;
   logic        held_q, held_d;
   logic        done_q, done_d;
   bin_t        exp_q, exp_d;
   logic        bad_q, bad_d;
   logic        flush_cnt_q, flush_cnt_d;
   logic [7:0]  dropped_q, dropped_d;
   logic        rvalid_q;

   logic        accept;
   logic        frame_start;
   logic        swap;
   logic        ack_ok;
   logic        start_bin;
   logic        rd_accept;
   logic [MAG_W-1:0] rd_data;

   assign ack_ok    = frame_ack && done_q;
   assign start_bin = dv && (xk_index == '0);
   assign rd_accept = rd_en && done_q;

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      state_d     = state_q;
      exp_d       = exp_q;
      bad_d       = bad_q;
      flush_cnt_d = flush_cnt_q;
      dropped_d   = dropped_q;
      accept      = 1'b0;
      frame_start = 1'b0;
      swap        = 1'b0;

      case (state_q)
         WR_IDLE: begin
            if (start_bin) begin
               accept      = 1'b1;
               frame_start = 1'b1;
               state_d     = WR_FILL;
            end
         end
         WR_FILL: begin
            if (dv) begin
               accept = 1'b1;
               exp_d  = exp_q + 1'b1;
               if (xk_index == '0) begin
                  frame_start = 1'b1;
               end else if (xk_index != exp_q) begin
                  bad_d = 1'b1;
               end
               if (xk_index == LAST_BIN) begin
                  flush_cnt_d = 1'b0;
                  state_d     = WR_FLUSH;
               end
            end
         end
         WR_FLUSH: begin
            if (flush_cnt_q != 1'(FLUSH_CYCLES - 1)) begin
               flush_cnt_d = flush_cnt_q + 1'b1;
            end else if (bad_q) begin
               state_d = WR_IDLE;
            end else if (!held_q || ack_ok) begin
               // The ack frees the read bank in time for this very swap.
               swap    = 1'b1;
               state_d = WR_IDLE;
            end else begin
               state_d = WR_WAIT_SWAP;
            end
         end
         WR_WAIT_SWAP: begin
            if (!held_q) begin
               swap    = 1'b1;
               state_d = WR_IDLE;
            end else if (start_bin) begin
               dropped_d   = sat_inc8(dropped_q);
               accept      = 1'b1;
               frame_start = 1'b1;
               state_d     = WR_FILL;
            end
         end
         default: state_d = WR_IDLE;
      endcase

      if (frame_start) begin
         bad_d = 1'b0;
         exp_d = bin_t'(1);
      end
   end

   assign wr_bank_d = swap ? ~wr_bank_q : wr_bank_q;

   // A normal swap raises fft_done one cycle after held; ack+swap together keep both high.
   always_comb begin
      held_d = held_q;
      if (ack_ok) begin
         held_d = 1'b0;
      end
      if (swap) begin
         held_d = 1'b1;
      end
      done_d = held_q && held_d;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= WR_IDLE;
         wr_bank_q   <= 1'b0;
         held_q      <= 1'b0;
         done_q      <= 1'b0;
         exp_q       <= '0;
         bad_q       <= 1'b0;
         flush_cnt_q <= 1'b0;
         dropped_q   <= '0;
         rvalid_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_bank_q   <= wr_bank_d;
         held_q      <= held_d;
         done_q      <= done_d;
         exp_q       <= exp_d;
         bad_q       <= bad_d;
         flush_cnt_q <= flush_cnt_d;
         dropped_q   <= dropped_d;
         rvalid_q    <= rd_accept;
      end
   end

   fft_bank_ram #(
      .AW (ADDR_W + 1),
      .DW (MAG_W)
   ) u_bank_ram (
      .clk     (clk),
      .reset   (reset),
      .we_i    (accept),
      .waddr_i ({wr_bank_q, xk_index}),
      .wdata_i ({xk_re, xk_im}),
      .re_i    (rd_accept),
      .raddr_i ({~wr_bank_q, fft_address}),
      .rdata_o (rd_data)
   );

   assign fft_done       = done_q;
   assign fft_read_valid = rvalid_q;
   assign data_in_real   = rd_data[MAG_W-1:DATA_W];
   assign data_in_imag   = rd_data[DATA_W-1:0];
   assign frames_dropped = dropped_q;

`ifdef FFT_FRAME_PEAK_EN
   logic signed [MAG_W-1:0] sq_re_q, sq_im_q;
   logic  s1_vld_q, s2_vld_q, s2_vld_d;
   bin_t  s1_bin_q, s2_bin_q;
   mag_t  mag_q;
   bin_t  cand_bin, run_bin_q, run_bin_d, peak_bin_q, peak_bin_d;
   mag_t  cand_mag, run_mag_q, run_mag_d, peak_mag_q, peak_mag_d;

   always_ff @(posedge clk) begin
      sq_re_q  <= MAG_W'($signed(xk_re)) * MAG_W'($signed(xk_re));
      sq_im_q  <= MAG_W'($signed(xk_im)) * MAG_W'($signed(xk_im));
      s1_bin_q <= xk_index;
      mag_q    <= $unsigned(sq_re_q) + $unsigned(sq_im_q);
      s2_bin_q <= s1_bin_q;
   end

   // A restart kills the bin still in flight so the old frame cannot leak into the new peak.
   assign s2_vld_d = s1_vld_q && !frame_start;

   always_comb begin
      cand_bin = run_bin_q;
      cand_mag = run_mag_q;
      if (s2_vld_q && (s2_bin_q >= MIN_BIN_IDX) && (mag_q > run_mag_q)) begin
         cand_bin = s2_bin_q;
         cand_mag = mag_q;
      end
      run_bin_d  = cand_bin;
      run_mag_d  = cand_mag;
      if (frame_start || swap) begin
         run_bin_d = '0;
         run_mag_d = '0;
      end
      peak_bin_d = swap ? cand_bin : peak_bin_q;
      peak_mag_d = swap ? cand_mag : peak_mag_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_vld_q   <= 1'b0;
         s2_vld_q   <= 1'b0;
         run_bin_q  <= '0;
         run_mag_q  <= '0;
         peak_bin_q <= '0;
         peak_mag_q <= '0;
      end else begin
         s1_vld_q   <= accept;
         s2_vld_q   <= s2_vld_d;
         run_bin_q  <= run_bin_d;
         run_mag_q  <= run_mag_d;
         peak_bin_q <= peak_bin_d;
         peak_mag_q <= peak_mag_d;
      end
   end

   assign peak_bin = peak_bin_q;
   assign peak_mag = peak_mag_q;
`else
   assign peak_bin = '0;
   assign peak_mag = '0;
`endif

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Directed bench for fft_frame_buffer: read scoreboard, swap timing, drops, bad frames, reset.
// Peak expectations follow FFT_FRAME_PEAK_EN the same way the design does.
module tb_fft_frame_buffer;
   import fft_pkg::*;

`ifdef FFT_FRAME_PEAK_EN
   localparam bit PEAK_EN = 1'b1;
`else
   localparam bit PEAK_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] xk_index;
   logic [DATA_W-1:0] xk_re, xk_im;
   logic              dv, frame_ack, rd_en;
   logic [ADDR_W-1:0] fft_address;
   logic              fft_done, fft_read_valid;
   logic [DATA_W-1:0] data_in_real, data_in_imag;
   logic [ADDR_W-1:0] peak_bin;
   logic [MAG_W-1:0]  peak_mag;
   logic [7:0]        frames_dropped;

   typedef struct packed {
      logic [DATA_W-1:0] re;
      logic [DATA_W-1:0] im;
   } rd_exp_t;

   rd_exp_t sb[$];
   int      n_checks = 0;
   int      n_pass   = 0;
   int      n_fail   = 0;
   bit      rv_watch = 1'b0;
   bit      rv_seen  = 1'b0;

   fft_frame_buffer dut (
      .clk            (clk),
      .reset          (reset),
      .xk_index       (xk_index),
      .xk_re          (xk_re),
      .xk_im          (xk_im),
      .dv             (dv),
      .frame_ack      (frame_ack),
      .fft_address    (fft_address),
      .rd_en          (rd_en),
      .fft_done       (fft_done),
      .fft_read_valid (fft_read_valid),
      .data_in_real   (data_in_real),
      .data_in_imag   (data_in_imag),
      .peak_bin       (peak_bin),
      .peak_mag       (peak_mag),
      .frames_dropped (frames_dropped)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: run did not finish, observed timeout required completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Stimulus patterns: value of real / imaginary part of bin b for frame kind k.
   function automatic int gv_re(input int k, input int b);
      case (k)
         0: return b;
         1: return (b == 0) ? -131072 : (b == 100) ? 1000 : (b == 200) ? -1000 : 0;
         2: return 3 * b - 700;
         3: return ((b * 37) % 1024) - 512;
         default: return 0;
      endcase
   endfunction

   function automatic int gv_im(input int k, input int b);
      case (k)
         1: return (b == 100) ? -1000 : (b == 200) ? 1000 : 0;
         2: return 500 - b;
         3: return 256 - ((b * 11) % 512);
         default: return 0;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] gen_re(input int k, input int b);
      int v;
      v = gv_re(k, b);
      return v[DATA_W-1:0];
   endfunction

   function automatic logic [DATA_W-1:0] gen_im(input int k, input int b);
      int v;
      v = gv_im(k, b);
      return v[DATA_W-1:0];
   endfunction

   // Reference peak: strict max of |X|^2 over eligible bins, lowest bin wins ties.
   task automatic model_peak(input int k, output logic [63:0] bin, output logic [63:0] mag);
      longint best;
      longint m;
      bin  = '0;
      best = 0;
      if (PEAK_EN) begin
         for (int b = MIN_BIN; b < FRAME_LEN; b++) begin
            m = longint'(gv_re(k, b)) * gv_re(k, b) + longint'(gv_im(k, b)) * gv_im(k, b);
            if (m > best) begin
               best = m;
               bin  = 64'(b);
            end
         end
      end
      mag = 64'(best);
   endtask

   task automatic tick();
      rd_exp_t e;
      @(posedge clk);
      #1;
      if (rv_watch && fft_read_valid) rv_seen = 1'b1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("rd_valid", 64'(fft_read_valid), 64'd1);
         check("rd_real", 64'(data_in_real), 64'(e.re));
         check("rd_imag", 64'(data_in_imag), 64'(e.im));
      end
   endtask

   task automatic send_bins(input int k, input int lo, input int hi, input int skip);
      for (int b = lo; b <= hi; b++) begin
         if (b != skip) begin
            dv       = 1'b1;
            xk_index = ADDR_W'(b);
            xk_re    = gen_re(k, b);
            xk_im    = gen_im(k, b);
            tick();
         end
      end
      dv = 1'b0;
   endtask

   // Called in the cycle after the bin-511 dv cycle; fft_done must rise exactly 4 cycles after it.
   task automatic check_present(input int k);
      logic [63:0] eb, em;
      check("done_t1", 64'(fft_done), 64'd0);
      tick();
      tick();
      check("done_t3", 64'(fft_done), 64'd0);
      tick();
      check("done_t4", 64'(fft_done), 64'd1);
      model_peak(k, eb, em);
      check("peak_bin", 64'(peak_bin), eb);
      check("peak_mag", 64'(peak_mag), em);
   endtask

   task automatic read_bins(input int k, input int a0, input int a1, input int a2);
      int addrs[3];
      addrs = '{a0, a1, a2};
      foreach (addrs[i]) begin
         rd_en       = 1'b1;
         fft_address = ADDR_W'(addrs[i]);
         sb.push_back('{re: gen_re(k, addrs[i]), im: gen_im(k, addrs[i])});
         tick();
      end
      rd_en = 1'b0;
   endtask

   task automatic do_ack();
      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
      check("ack_clears_done", 64'(fft_done), 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_done"}, 64'(fft_done), 64'd0);
      check({tag, "_rvalid"}, 64'(fft_read_valid), 64'd0);
      check({tag, "_real"}, 64'(data_in_real), 64'd0);
      check({tag, "_imag"}, 64'(data_in_imag), 64'd0);
      check({tag, "_pbin"}, 64'(peak_bin), 64'd0);
      check({tag, "_pmag"}, 64'(peak_mag), 64'd0);
      check({tag, "_dropped"}, 64'(frames_dropped), 64'd0);
   endtask

   initial begin
      logic [63:0] eb, em;
      bit done_seen;

      reset       = 1'b1;
      dv          = 1'b0;
      xk_index    = '0;
      xk_re       = '0;
      xk_im       = '0;
      frame_ack   = 1'b0;
      rd_en       = 1'b0;
      fft_address = '0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset = 1'b0;
      tick();

      // Ramp frame: peak at the last bin, single and back-to-back reads.
      send_bins(0, 0, FRAME_LEN - 1, -1);
      check_present(0);
      check("ramp_peak_bin", 64'(peak_bin), PEAK_EN ? 64'd511 : 64'd0);
      check("ramp_peak_mag", 64'(peak_mag), PEAK_EN ? 64'd261121 : 64'd0);
      read_bins(0, 37, 0, 511);
      read_bins(0, 255, 1, 254);
      do_ack();
      rd_en       = 1'b1;
      fft_address = ADDR_W'(3);
      tick();
      rd_en = 1'b0;
      check("rd_no_done_valid", 64'(fft_read_valid), 64'd0);
      check("rd_no_done_hold", 64'(data_in_real), 64'd254);

      // DC excluded, tie at bin 200 keeps bin 100.
      send_bins(1, 0, FRAME_LEN - 1, -1);
      check_present(1);
      check("dc_peak_bin", 64'(peak_bin), PEAK_EN ? 64'd100 : 64'd0);
      check("dc_peak_mag", 64'(peak_mag), PEAK_EN ? 64'd2000000 : 64'd0);
      read_bins(1, 0, 100, 200);
      do_ack();

      // Skipped index: frame discarded, next clean frame presented.
      send_bins(2, 0, FRAME_LEN - 1, 300);
      done_seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (fft_done) done_seen = 1'b1;
      end
      check("bad_frame_no_done", 64'(done_seen), 64'd0);
      send_bins(2, 0, FRAME_LEN - 1, -1);
      check_present(2);

      // Frame B completes while A is held, then C starts: B dropped, A still readable.
      send_bins(3, 0, FRAME_LEN - 1, -1);
      repeat (6) tick();
      check("wait_done_held", 64'(fft_done), 64'd1);
      model_peak(2, eb, em);
      check("wait_peak_a", 64'(peak_bin), eb);
      check("wait_dropped0", 64'(frames_dropped), 64'd0);
      send_bins(0, 0, 199, -1);
      check("dropped_one", 64'(frames_dropped), 64'd1);
      read_bins(2, 1, 300, 511);
      do_ack();
      send_bins(0, 200, FRAME_LEN - 1, -1);
      check_present(0);
      check("dropped_still_one", 64'(frames_dropped), 64'd1);
      read_bins(0, 42, 43, 500);

      // Ack coincident with the end of FLUSH: no low cycle on fft_done.
      send_bins(1, 0, FRAME_LEN - 1, -1);
      model_peak(0, eb, em);
      check("coin_old_peak", 64'(peak_bin), eb);
      check("coin_done_t1", 64'(fft_done), 64'd1);
      tick();
      frame_ack = 1'b1;
      check("coin_done_t2", 64'(fft_done), 64'd1);
      tick();
      frame_ack = 1'b0;
      check("coin_done_t3", 64'(fft_done), 64'd1);
      model_peak(1, eb, em);
      check("coin_new_peak_bin", 64'(peak_bin), eb);
      check("coin_new_peak_mag", 64'(peak_mag), em);
      tick();
      check("coin_done_t4", 64'(fft_done), 64'd1);
      read_bins(1, 100, 200, 0);
      read_bins(1, 100, 7, 200);

      // Reset in the middle of bin 250, then stray tail bins, then a clean frame.
      send_bins(3, 0, 249, -1);
      dv       = 1'b1;
      xk_index = ADDR_W'(250);
      xk_re    = gen_re(3, 250);
      xk_im    = gen_im(3, 250);
      #3;
      reset = 1'b1;
      #1;
      check_all_zero("midreset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      dv    = 1'b0;
      send_bins(3, 251, FRAME_LEN - 1, -1);
      done_seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (fft_done) done_seen = 1'b1;
      end
      check("tail_after_reset_ignored", 64'(done_seen), 64'd0);
      rv_watch    = 1'b1;
      rd_en       = 1'b1;
      fft_address = ADDR_W'(5);
      send_bins(3, 0, FRAME_LEN - 1, -1);
      rd_en    = 1'b0;
      rv_watch = 1'b0;
      check("rd_before_done_valid", 64'(rv_seen), 64'd0);
      check("rd_before_done_hold", 64'(data_in_real), 64'd0);
      check_present(3);
      read_bins(3, 5, 250, 511);
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
